// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display source stage.
package hex_disp_pkg;

    // Display page selector; the order is the button cycling order.
    typedef enum logic [1:0] {
        PG_A    = 2'd0,
        PG_B    = 2'd1,
        PG_RES  = 2'd2,
        PG_FLAG = 2'd3
    } page_e;

    localparam page_e PG_RESET = PG_RES;

    // Bit positions inside the FPU exception flag vector.
    typedef enum int unsigned {
        FLAG_INEXACT   = 0,
        FLAG_UNDERFLOW = 1,
        FLAG_OVERFLOW  = 2,
        FLAG_DIVZERO   = 3,
        FLAG_INVALID   = 4
    } flag_idx_e;

    // Next page in the button cycling order, wrapping after the flags page.
    function automatic page_e next_page(input page_e p);
        case (p)
            PG_A:    return PG_B;
            PG_B:    return PG_RES;
            PG_RES:  return PG_FLAG;
            default: return PG_A;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer + debouncer producing a one-cycle press event.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned DB_CNT_W  = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic                level_q;
    logic [DB_CNT_W-1:0] cnt_q;
    logic                press_q;
    logic                fall_c;

    // Debounced level is about to drop from released to pressed.
    assign fall_c = (sync2_q != level_q) && (cnt_q == CNT_MAX) && !sync2_q;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Stability counter; a level is accepted after DB_CYCLES differing cycles in a row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else if (sync2_q == level_q) begin
            cnt_q   <= '0;
        end else if (cnt_q == CNT_MAX) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + DB_CNT_W'(1);
        end
    end

    // Registered one-cycle press event on the debounced falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= fall_c;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// FPU capture registers, page selection and display word/update pulse.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int unsigned SIZE_DATA = 32,
    parameter int unsigned SIZE_FLAG = 5,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned DB_CNT_W  = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_fpu_valid,
    input  logic [SIZE_DATA-1:0] i_fpu_op_a,
    input  logic [SIZE_DATA-1:0] i_fpu_op_b,
    input  logic [SIZE_DATA-1:0] i_fpu_result,
    input  logic [SIZE_FLAG-1:0] i_fpu_flags,
    input  logic                 i_btn_next_n,
    input  logic                 i_sw_hold,
    output logic [SIZE_DATA-1:0] o_hex_data,
    output logic                 o_hex_en,
    output logic [1:0]           o_page
);

    logic                 press;
    logic                 cap_c;
    logic [SIZE_DATA-1:0] a_q;
    logic [SIZE_DATA-1:0] b_q;
    logic [SIZE_DATA-1:0] res_q;
    logic [SIZE_FLAG-1:0] flags_q;
    page_e                page_q;
    logic                 init_q;
    logic                 upd_q;
    logic                 en_q;
    logic [SIZE_DATA-1:0] data_q;
    logic [SIZE_DATA-1:0] disp_c;
    page_e                page_out_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_CNT_W  (DB_CNT_W)
    ) u_btn_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn_n (i_btn_next_n),
        .o_press (press)
    );

    // Hold switch masks captures completely.
    assign cap_c = i_fpu_valid && !i_sw_hold;

    // Capture operands, result and flags of a completed operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else if (cap_c) begin
            a_q     <= i_fpu_op_a;
            b_q     <= i_fpu_op_b;
            res_q   <= i_fpu_result;
            flags_q <= i_fpu_flags;
        end
    end

    // Page FSM: advance one page per press event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            page_q <= PG_RESET;
        end else if (press) begin
            page_q <= next_page(page_q);
        end
    end

    // Select the captured word for the current page.
    always_comb begin
        disp_c = '0;
        case (page_q)
            PG_A:    disp_c = a_q;
            PG_B:    disp_c = b_q;
            PG_RES:  disp_c = res_q;
            PG_FLAG: disp_c = SIZE_DATA'(flags_q);
            default: disp_c = '0;
        endcase
    end

    // Update pulse: one after reset, then one cycle after every capture/press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_q <= 1'b1;
            upd_q  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            init_q <= 1'b0;
            upd_q  <= cap_c || press;
            en_q   <= init_q || upd_q;
        end
    end

    // Registered display word and page, aligned with the update pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q     <= '0;
            page_out_q <= PG_RESET;
        end else begin
            data_q     <= disp_c;
            page_out_q <= page_q;
        end
    end

    assign o_hex_data = data_q;
    assign o_hex_en   = en_q;
    assign o_page     = page_out_q;

endmodule
